// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Bounded-burst round-robin between port A (core) and port B (loader/debug).
module ram_arbiter #(
  parameter int unsigned BURST = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    A_OWN = 2'd1,
    B_OWN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_room;
  logic          r_last;     // 0: A served last, 1: B served last
  logic          r_rd_v;
  logic          r_rd_who;   // 0: A, 1: B
  logic          w_gnt_a;
  logic          w_gnt_b;

  assign w_room    = (r_cnt < CW'(BURST));
  assign w_cnt_inc = (r_cnt == CW'(BURST)) ? r_cnt : r_cnt + CW'(1);

  // Arbitration: owner keeps the RAM while under budget or uncontested.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_req && b_req) begin
          w_gnt_a = r_last;
          w_gnt_b = ~r_last;
        end else begin
          w_gnt_a = a_req;
          w_gnt_b = b_req;
        end
      end
      A_OWN: begin
        if (a_req && (w_room || !b_req)) w_gnt_a = 1'b1;
        else if (b_req)                  w_gnt_b = 1'b1;
      end
      B_OWN: begin
        if (b_req && (w_room || !a_req)) w_gnt_b = 1'b1;
        else if (a_req)                  w_gnt_a = 1'b1;
      end
      default: begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
      end
    endcase
  end

  // Next ownership and burst count.
  always_comb begin
    w_state_nxt = IDLE;
    w_cnt_nxt   = '0;
    if (w_gnt_a) begin
      w_state_nxt = A_OWN;
      w_cnt_nxt   = (r_state == A_OWN) ? w_cnt_inc : CW'(1);
    end else if (w_gnt_b) begin
      w_state_nxt = B_OWN;
      w_cnt_nxt   = (r_state == B_OWN) ? w_cnt_inc : CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= 1'b1;
      r_rd_v   <= 1'b0;
      r_rd_who <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      if (w_gnt_a || w_gnt_b) r_last <= w_gnt_b;
      r_rd_v   <= (w_gnt_a && !a_we) || (w_gnt_b && !b_we);
      r_rd_who <= w_gnt_b;
    end
  end

  // Grants are suppressed while reset is held so the RAM sees no access.
  assign a_gnt = w_gnt_a & rst_n;
  assign b_gnt = w_gnt_b & rst_n;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (a_gnt) begin
      mem_addr = a_addr;
      mem_din  = a_wdata;
      mem_we   = a_we;
    end else if (b_gnt) begin
      mem_addr = b_addr;
      mem_din  = b_wdata;
      mem_we   = b_we;
    end
  end

  assign a_rvalid = r_rd_v & ~r_rd_who;
  assign b_rvalid = r_rd_v &  r_rd_who;
  assign rdata    = mem_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle grant checks plus a read-return
// scoreboard drained by an independent monitor.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;

  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
  logic [15:0] rdata, mem_addr, mem_din;
  logic [15:0] mem_dout = '0;

  logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, mem_we1;
  logic [15:0] rdata1, mem_addr1, mem_din1;
  logic [15:0] zero16 = '0;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        who;
    logic [15:0] data;
  } resp_t;
  resp_t sb[$];

  logic [15:0] ram [0:65535];
  logic [15:0] wr_shadow [int];

  always #5 clk = ~clk;

  ram_arbiter #(.BURST(4), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  ram_arbiter #(.BURST(1), .AW(16), .DW(16)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1),
    .rdata(rdata1), .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_we(mem_we1),
    .mem_dout(zero16)
  );

  // Synchronous single-port RAM, read-before-write.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  function automatic logic [15:0] exp_data(input logic [15:0] addr);
    if (wr_shadow.exists(int'(addr))) return wr_shadow[int'(addr)];
    if (addr == 16'h0020) return 16'h0003;
    return addr ^ 16'hA5A5;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int gcode(input logic ga, input logic gb);
    return int'({gb, ga});
  endfunction

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_gnt && b_gnt) chk("dual_gnt", 1, 0);
      if (a_rvalid && b_rvalid) chk("dual_rvalid", 1, 0);
      if (a_rvalid || b_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", int'({b_rvalid, a_rvalid}), 0);
        end else begin
          resp_t e;
          e = sb.pop_front();
          chk("rvalid_port", int'(b_rvalid), int'(e.who));
          chk("rdata", int'(rdata), int'(e.data));
        end
      end
    end
  end

  // One cycle: drive, check grants/RAM pins at negedge, advance past posedge.
  // e4/e1: 0 none, 1 A, 2 B; e1 < 0 skips the BURST=1 instance.
  task automatic step(input logic ar, input logic aw, input logic [15:0] aa,
                      input logic [15:0] ad, input logic br, input logic bw,
                      input logic [15:0] ba, input logic [15:0] bd,
                      input int e4, input int e1 = -1);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    chk("gnt", gcode(a_gnt, b_gnt), e4);
    if (e1 >= 0) chk("gnt_burst1", gcode(a_gnt1, b_gnt1), e1);
    if (e4 == 0) begin
      chk("idle_pins", int'({mem_we, mem_addr, mem_din}), 0);
    end else begin
      logic        w;
      logic [15:0] ad_w, d_w;
      w    = (e4 == 1) ? aw : bw;
      ad_w = (e4 == 1) ? aa : ba;
      d_w  = (e4 == 1) ? ad : bd;
      chk("mem_addr", int'(mem_addr), int'(ad_w));
      chk("mem_we", int'(mem_we), int'(w));
      if (w) begin
        chk("mem_din", int'(mem_din), int'(d_w));
        wr_shadow[int'(ad_w)] = d_w;
      end else begin
        sb.push_back('{who: (e4 == 2), data: exp_data(ad_w)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int e1 = -1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 0, e1);
  endtask

  // Reset with both ports requesting; all outputs must stay low.
  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h1234; a_wdata = 16'h5678;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h4321; b_wdata = 16'h8765;
    @(negedge clk);
    chk("rst_gnt", gcode(a_gnt, b_gnt), 0);
    chk("rst_rvalid", int'({a_rvalid, b_rvalid}), 0);
    chk("rst_mem", int'({mem_we, mem_addr, mem_din}), 0);
    sb.delete();
    @(posedge clk);
    #1;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    string seq;
    int ai, bi;
    for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'hA5A5;
    ram[16'h0020] = 16'h0003;

    do_reset();
    idle();

    // Single reads, including the top address, then write-then-read.
    step(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    step(1, 0, 16'hFFFF, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    step(0, 0, 16'h0, 16'h0, 1, 1, 16'h0040, 16'hBEEF, 2);
    step(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    idle();
    idle();

    // Continuous contention from reset.
    do_reset();
    seq = "AAAABBBBAAAA";
    ai = 0; bi = 0;
    for (int i = 0; i < seq.len(); i++) begin
      step(1, 0, 16'h0100 + 16'(ai), 16'h0, 1, 0, 16'h0200 + 16'(bi), 16'h0,
           (seq[i] == "A") ? 1 : 2);
      if (seq[i] == "A") ai++; else bi++;
    end
    idle();
    idle();

    // Lone requester beyond BURST, then B breaks in.
    for (int i = 0; i < 10; i++)
      step(1, 0, 16'h0300 + 16'(i), 16'h0, 0, 0, 16'h0, 16'h0, 1);
    step(1, 0, 16'h030A, 16'h0, 1, 0, 16'h0400, 16'h0, 2);
    step(1, 0, 16'h030A, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    idle();
    idle();

    // Tie after idle with A served last: B first; BURST=1 alternates.
    step(1, 0, 16'h0500, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1);
    idle(0);
    seq = "BBBBAA";
    ai = 1; bi = 0;
    for (int i = 0; i < seq.len(); i++) begin
      step(1, 0, 16'h0500 + 16'(ai), 16'h0, 1, 0, 16'h0600 + 16'(bi), 16'h0,
           (seq[i] == "A") ? 1 : 2, (i % 2 == 0) ? 2 : 1);
      if (seq[i] == "A") ai++; else bi++;
    end
    idle();
    idle();

    // Reset one cycle after a granted read: the return must be dropped.
    step(1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 1);
    do_reset();
    idle();
    idle();
    step(1, 0, 16'h0021, 16'h0, 0, 0, 16'h0, 16'h0, 1, 1);
    idle();
    idle();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
